// File: rtl/mem_bus_arbiter_rr_if.sv
// Requester and memory-side signal bundle for mem_bus_arbiter_rr.
interface mem_bus_arbiter_rr_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    // Requester side
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          rsp_err;

    // Main-memory side
    logic                          mem_req_valid;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic                          mem_we;
    logic [DATA_WIDTH-1:0]         mem_wdata;
    logic                          mem_data_valid;
    logic [DATA_WIDTH-1:0]         mem_rdata;

    // Arbiter view
    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, mem_data_valid, mem_rdata,
        output grant, rsp_valid, rsp_rdata, rsp_err,
        output mem_req_valid, mem_addr, mem_we, mem_wdata
    );

    // Environment view (requesters plus memory model)
    modport master (
        output req_valid, req_addr, req_we, req_wdata, mem_data_valid, mem_rdata,
        input  grant, rsp_valid, rsp_rdata, rsp_err,
        input  mem_req_valid, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter_rr.sv
// N-port arbiter onto a single main-memory bus: fixed or round-robin priority,
// one transaction in flight, response timeout with error flag, flush and stall.
module mem_bus_arbiter_rr #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned RR_MODE        = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                 clk,
    input logic                 reset,
    input logic                 system_flush,
    input logic                 system_stall,
    mem_bus_arbiter_rr_if.slave bus
);

    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic [IDX_W-1:0]      win;
    logic [IDX_W-1:0]      rr_idx;
    logic                  win_found;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_we;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Winner selection: rotate from rr_ptr+1, or highest asserted index in fixed mode
    always_comb begin
        win       = '0;
        rr_idx    = '0;
        win_found = 1'b0;
        if (RR_MODE != 0) begin
            for (int k = 1; k <= int'(NUM_REQ); k++) begin
                rr_idx = IDX_W'((int'(rr_ptr_q) + k) % int'(NUM_REQ));
                if (!win_found && bus.req_valid[rr_idx]) begin
                    win_found = 1'b1;
                    win       = rr_idx;
                end
            end
        end else begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (bus.req_valid[i]) begin
                    win_found = 1'b1;
                    win       = IDX_W'(i);
                end
            end
        end
    end

    // Route the winning port's request fields
    always_comb begin
        sel_addr  = '0;
        sel_we    = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (win == IDX_W'(i)) begin
                sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_we    = bus.req_we[i];
                sel_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            rr_ptr_q        <= IDX_W'(NUM_REQ - 1);
            owner_q         <= '0;
            cnt_q           <= '0;
            grant_q         <= '0;
            rsp_valid_q     <= '0;
            rsp_rdata_q     <= '0;
            rsp_err_q       <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_we_q        <= 1'b0;
            mem_wdata_q     <= '0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            owner_q         <= owner_d;
            cnt_q           <= cnt_d;
            grant_q         <= grant_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            rsp_err_q       <= rsp_err_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_addr_q      <= mem_addr_d;
            mem_we_q        <= mem_we_d;
            mem_wdata_q     <= mem_wdata_d;
        end
    end

    // Next-state and next-output logic; grant and response are single-cycle pulses
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        owner_d         = owner_q;
        cnt_d           = cnt_q;
        grant_d         = '0;
        rsp_valid_d     = '0;
        rsp_rdata_d     = '0;
        rsp_err_d       = 1'b0;
        mem_req_valid_d = mem_req_valid_q;
        mem_addr_d      = mem_addr_q;
        mem_we_d        = mem_we_q;
        mem_wdata_d     = mem_wdata_q;

        if (system_flush) begin
            state_d         = IDLE;
            mem_req_valid_d = 1'b0;
            cnt_d           = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found && !system_stall) begin
                        grant_d         = NUM_REQ'(1) << win;
                        mem_req_valid_d = 1'b1;
                        mem_addr_d      = sel_addr;
                        mem_we_d        = sel_we;
                        mem_wdata_d     = sel_we ? sel_wdata : '0;
                        owner_d         = win;
                        cnt_d           = '0;
                        if (RR_MODE != 0) begin
                            rr_ptr_d = win;
                        end
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    // Data takes precedence over a coincident timeout
                    if (bus.mem_data_valid) begin
                        mem_req_valid_d = 1'b0;
                        rsp_valid_d     = NUM_REQ'(1) << owner_q;
                        rsp_rdata_d     = mem_we_q ? '0 : bus.mem_rdata;
                        rsp_err_d       = 1'b0;
                        state_d         = RESP;
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
                        mem_req_valid_d = 1'b0;
                        rsp_valid_d     = NUM_REQ'(1) << owner_q;
                        rsp_rdata_d     = '0;
                        rsp_err_d       = 1'b1;
                        state_d         = RESP;
                    end
                end
                RESP: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.grant         = grant_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_err       = rsp_err_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter_rr.sv
// Directed bench for mem_bus_arbiter_rr: a round-robin and a fixed-priority instance.
module tb_mem_bus_arbiter_rr;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic reset;
    logic system_flush;
    logic system_stall;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_g;

    mem_bus_arbiter_rr_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_rr ();
    mem_bus_arbiter_rr_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_fp ();

    mem_bus_arbiter_rr #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1), .TIMEOUT_CYCLES(8)
    ) u_rr (
        .clk(clk), .reset(reset), .system_flush(system_flush),
        .system_stall(system_stall), .bus(bus_rr)
    );

    mem_bus_arbiter_rr #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(0), .TIMEOUT_CYCLES(8)
    ) u_fp (
        .clk(clk), .reset(reset), .system_flush(system_flush),
        .system_stall(system_stall), .bus(bus_fp)
    );

    always #5 clk = ~clk;

    // Advance one active edge, then settle before sampling or driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        system_flush = 1'b0;
        system_stall = 1'b0;
        bus_rr.req_valid = '0; bus_rr.req_addr = '0; bus_rr.req_we = '0; bus_rr.req_wdata = '0;
        bus_rr.mem_data_valid = 1'b0; bus_rr.mem_rdata = '0;
        bus_fp.req_valid = '0; bus_fp.req_addr = '0; bus_fp.req_we = '0; bus_fp.req_wdata = '0;
        bus_fp.mem_data_valid = 1'b0; bus_fp.mem_rdata = '0;
        tick(); tick();

        // Reset state
        chk("rst_grant", bus_rr.grant, 64'h0);
        chk("rst_rsp_valid", bus_rr.rsp_valid, 64'h0);
        chk("rst_mem_req_valid", bus_rr.mem_req_valid, 64'h0);
        chk("rst_mem_addr", bus_rr.mem_addr, 64'h0);
        chk("rst_rsp_err", bus_rr.rsp_err, 64'h0);
        chk("rst_fp_mem_req_valid", bus_fp.mem_req_valid, 64'h0);
        reset = 1'b0;

        // Single port read, memory answers after two cycles
        bus_rr.req_valid = 4'b0100;
        bus_rr.req_addr[2*AW +: AW] = 32'h100;
        bus_rr.req_we[2] = 1'b0;
        tick();
        chk("t1_grant", bus_rr.grant, 64'b0100);
        chk("t1_mem_req_valid", bus_rr.mem_req_valid, 64'h1);
        chk("t1_mem_addr", bus_rr.mem_addr, 64'h100);
        chk("t1_mem_we", bus_rr.mem_we, 64'h0);
        chk("t1_mem_wdata", bus_rr.mem_wdata, 64'h0);
        bus_rr.req_valid = 4'b0000;
        tick();
        chk("t1_grant_pulse", bus_rr.grant, 64'h0);
        bus_rr.mem_data_valid = 1'b1;
        bus_rr.mem_rdata = 32'hDEADBEEF;
        tick();
        chk("t1_rsp_valid", bus_rr.rsp_valid, 64'b0100);
        chk("t1_rsp_rdata", bus_rr.rsp_rdata, 64'hDEADBEEF);
        chk("t1_rsp_err", bus_rr.rsp_err, 64'h0);
        chk("t1_mem_req_drop", bus_rr.mem_req_valid, 64'h0);
        bus_rr.mem_data_valid = 1'b0;
        tick();
        chk("t1_rsp_clear", bus_rr.rsp_valid, 64'h0);
        chk("t1_rdata_clear", bus_rr.rsp_rdata, 64'h0);

        // Round-robin fairness from a fresh reset; memory strobe held high
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_rr.req_valid = 4'b1111;
        bus_rr.mem_data_valid = 1'b1;
        bus_rr.mem_rdata = 32'h55;
        for (int n = 0; n < 6; n++) begin
            exp_g = 4'b0001 << (n % 4);
            tick();
            chk("t2_grant", bus_rr.grant, 64'(exp_g));
            tick();
            chk("t2_rsp_valid", bus_rr.rsp_valid, 64'(exp_g));
            chk("t2_rsp_rdata", bus_rr.rsp_rdata, 64'h55);
            tick();
            chk("t2_idle_grant", bus_rr.grant, 64'h0);
            chk("t2_idle_rsp", bus_rr.rsp_valid, 64'h0);
        end
        bus_rr.req_valid = 4'b0000;
        bus_rr.mem_data_valid = 1'b0;

        // Fixed priority: port 3 starves port 0 until it drops
        bus_fp.req_valid = 4'b1001;
        bus_fp.req_addr[0*AW +: AW] = 32'h10;
        bus_fp.req_addr[3*AW +: AW] = 32'h30;
        bus_fp.mem_data_valid = 1'b1;
        bus_fp.mem_rdata = 32'h1234;
        tick();
        chk("t3_grant_a", bus_fp.grant, 64'b1000);
        chk("t3_addr_a", bus_fp.mem_addr, 64'h30);
        tick();
        chk("t3_rsp_a", bus_fp.rsp_valid, 64'b1000);
        tick();
        tick();
        chk("t3_grant_b", bus_fp.grant, 64'b1000);
        bus_fp.req_valid = 4'b0001;
        tick();
        chk("t3_rsp_b", bus_fp.rsp_valid, 64'b1000);
        tick();
        tick();
        chk("t3_grant_c", bus_fp.grant, 64'b0001);
        chk("t3_addr_c", bus_fp.mem_addr, 64'h10);
        bus_fp.req_valid = 4'b0000;
        tick();
        chk("t3_rsp_c", bus_fp.rsp_valid, 64'b0001);
        bus_fp.mem_data_valid = 1'b0;
        tick();

        // Write path (rr_ptr = 1, port 1 only requester)
        bus_rr.req_valid = 4'b0010;
        bus_rr.req_addr[1*AW +: AW] = 32'h40;
        bus_rr.req_we[1] = 1'b1;
        bus_rr.req_wdata[1*DW +: DW] = 32'hA5A5A5A5;
        bus_rr.mem_rdata = 32'hFFFFFFFF;
        tick();
        chk("t4_grant", bus_rr.grant, 64'b0010);
        chk("t4_mem_addr", bus_rr.mem_addr, 64'h40);
        bus_rr.req_valid = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t4_mem_we", bus_rr.mem_we, 64'h1);
            chk("t4_mem_wdata", bus_rr.mem_wdata, 64'hA5A5A5A5);
            chk("t4_mem_req_valid", bus_rr.mem_req_valid, 64'h1);
        end
        bus_rr.mem_data_valid = 1'b1;
        tick();
        chk("t4_rsp_valid", bus_rr.rsp_valid, 64'b0010);
        chk("t4_rsp_rdata", bus_rr.rsp_rdata, 64'h0);
        bus_rr.mem_data_valid = 1'b0;
        bus_rr.req_we[1] = 1'b0;
        tick();

        // Timeout: port 0 read, no memory answer (rr_ptr = 1 -> port 0)
        bus_rr.req_valid = 4'b0001;
        bus_rr.req_addr[0*AW +: AW] = 32'h200;
        bus_rr.mem_rdata = 32'h77;
        tick();
        chk("t5_grant", bus_rr.grant, 64'b0001);
        chk("t5_mem_req_valid", bus_rr.mem_req_valid, 64'h1);
        bus_rr.req_valid = 4'b0000;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("t5_busy_req", bus_rr.mem_req_valid, 64'h1);
            chk("t5_busy_rsp", bus_rr.rsp_valid, 64'h0);
        end
        tick();
        chk("t5_req_drop", bus_rr.mem_req_valid, 64'h0);
        chk("t5_rsp_valid", bus_rr.rsp_valid, 64'b0001);
        chk("t5_rsp_err", bus_rr.rsp_err, 64'h1);
        chk("t5_rsp_rdata", bus_rr.rsp_rdata, 64'h0);
        tick();
        chk("t5_err_clear", bus_rr.rsp_err, 64'h0);

        // Data and timeout in the same cycle: data wins (rr_ptr = 0 -> port 1)
        bus_rr.req_valid = 4'b0010;
        bus_rr.req_addr[1*AW +: AW] = 32'h44;
        tick();
        chk("t5b_grant", bus_rr.grant, 64'b0010);
        bus_rr.req_valid = 4'b0000;
        for (int i = 1; i < 8; i++) tick();
        bus_rr.mem_data_valid = 1'b1;
        bus_rr.mem_rdata = 32'hCAFEF00D;
        tick();
        chk("t5b_rsp_valid", bus_rr.rsp_valid, 64'b0010);
        chk("t5b_rsp_err", bus_rr.rsp_err, 64'h0);
        chk("t5b_rsp_rdata", bus_rr.rsp_rdata, 64'hCAFEF00D);
        bus_rr.mem_data_valid = 1'b0;
        tick();

        // Flush in BUSY with coincident data (rr_ptr = 1 -> port 2 wins)
        bus_rr.req_valid = 4'b0101;
        tick();
        chk("t6_grant", bus_rr.grant, 64'b0100);
        bus_rr.req_valid = 4'b0000;
        tick();
        system_flush = 1'b1;
        bus_rr.mem_data_valid = 1'b1;
        bus_rr.mem_rdata = 32'h1111;
        tick();
        chk("t6_flush_rsp", bus_rr.rsp_valid, 64'h0);
        chk("t6_flush_req", bus_rr.mem_req_valid, 64'h0);
        chk("t6_flush_grant", bus_rr.grant, 64'h0);
        system_flush = 1'b0;
        bus_rr.mem_data_valid = 1'b0;
        bus_rr.req_valid = 4'b1001;
        bus_rr.req_addr[3*AW +: AW] = 32'h300;
        bus_rr.req_addr[0*AW +: AW] = 32'h10;
        tick();
        chk("t6_post_grant", bus_rr.grant, 64'b1000);
        chk("t6_post_addr", bus_rr.mem_addr, 64'h300);
        chk("t6_post_rsp", bus_rr.rsp_valid, 64'h0);
        bus_rr.req_valid = 4'b0000;
        bus_rr.mem_data_valid = 1'b1;
        tick();
        chk("t6_post_rsp_valid", bus_rr.rsp_valid, 64'b1000);
        bus_rr.mem_data_valid = 1'b0;
        tick();

        // Stall held in IDLE blocks arbitration
        system_stall = 1'b1;
        bus_rr.req_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t7_stall_grant", bus_rr.grant, 64'h0);
            chk("t7_stall_req", bus_rr.mem_req_valid, 64'h0);
        end
        system_stall = 1'b0;
        tick();
        chk("t7_grant", bus_rr.grant, 64'b0001);
        chk("t7_addr", bus_rr.mem_addr, 64'h10);
        bus_rr.req_valid = 4'b0000;
        bus_rr.mem_data_valid = 1'b1;
        tick();
        chk("t7_rsp", bus_rr.rsp_valid, 64'b0001);
        bus_rr.mem_data_valid = 1'b0;
        tick();

        // Reset in the middle of a write transaction
        bus_rr.req_valid = 4'b0100;
        bus_rr.req_we[2] = 1'b1;
        bus_rr.req_wdata[2*DW +: DW] = 32'h5A;
        tick();
        chk("t8_grant", bus_rr.grant, 64'b0100);
        bus_rr.req_valid = 4'b0000;
        tick();
        chk("t8_busy", bus_rr.mem_req_valid, 64'h1);
        chk("t8_busy_we", bus_rr.mem_we, 64'h1);
        reset = 1'b1;
        tick();
        chk("t8_rst_req", bus_rr.mem_req_valid, 64'h0);
        chk("t8_rst_addr", bus_rr.mem_addr, 64'h0);
        chk("t8_rst_we", bus_rr.mem_we, 64'h0);
        chk("t8_rst_wdata", bus_rr.mem_wdata, 64'h0);
        chk("t8_rst_grant", bus_rr.grant, 64'h0);
        chk("t8_rst_rsp", bus_rr.rsp_valid, 64'h0);
        reset = 1'b0;
        tick();
        chk("t8_after_rst", bus_rr.mem_req_valid, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
